// File: rtl/alu_host_sequencer.sv
// rtl/alu_host_sequencer.sv - initiator for the sequential ALU operand/result bus
// Loads operands word by word, waits for END with a watchdog, returns one response.
module alu_host_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_x,
    input  logic [7:0]  req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] OP_DIV = 2'b11;

    state_t          state_q;
    logic [1:0]      op_q;
    logic [15:0]     x_q;
    logic [7:0]      y_q;
    logic [1:0]      k_q;
    logic [TO_W-1:0] wd_q;
    logic [7:0]      h0_q, h1_q;
    logic            end_q;

    logic [1:0]      n_words;
    logic            end_rise;

    // Divide sends the 16-bit dividend as A (high) then Q (low); others send X[7:0] then Y.
    function automatic logic [7:0] word_sel(input logic [1:0] op, input logic [15:0] x,
                                            input logic [7:0] y, input logic [1:0] k);
        logic [7:0] w;
        w = y;
        case (k)
            2'd0:    w = (op == OP_DIV) ? x[15:8] : x[7:0];
            2'd1:    w = (op == OP_DIV) ? x[7:0]  : y;
            default: w = y;
        endcase
        return w;
    endfunction

    assign n_words  = (op_q == OP_DIV) ? 2'd3 : 2'd2;
    assign end_rise = alu_end & ~end_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            x_q         <= 16'h0000;
            y_q         <= 8'h00;
            k_q         <= 2'd0;
            wd_q        <= '0;
            h0_q        <= 8'h00;
            h1_q        <= 8'h00;
            end_q       <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_result  <= 16'h0000;
            rsp_err     <= 1'b0;
            alu_begin   <= 1'b0;
            alu_op_code <= 2'b00;
            alu_inbus   <= 8'h00;
        end else begin
            end_q <= alu_end;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        x_q         <= req_x;
                        y_q         <= req_y;
                        k_q         <= 2'd1;
                        req_ready   <= 1'b0;
                        alu_begin   <= 1'b1;
                        alu_op_code <= req_op;
                        alu_inbus   <= word_sel(req_op, req_x, req_y, 2'd0);
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    alu_begin <= 1'b0;
                    if (k_q < n_words) begin
                        alu_inbus <= word_sel(op_q, x_q, y_q, k_q);
                        k_q       <= k_q + 2'd1;
                    end else begin
                        alu_inbus <= 8'h00;
                        wd_q      <= '0;
                        h0_q      <= 8'h00;
                        h1_q      <= 8'h00;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (end_rise) begin
                        // The byte on outbus during the END cycle is not part of the result.
                        rsp_result  <= (op_q[1] == 1'b0) ? {{8{h0_q[7]}}, h0_q} : {h1_q, h0_q};
                        rsp_err     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        alu_op_code <= 2'b00;
                        state_q     <= S_RESP;
                    end else begin
                        h1_q <= h0_q;
                        h0_q <= alu_outbus;
                        if (wd_q >= TO_W'(TIMEOUT - 1)) begin
                            rsp_result  <= 16'h0000;
                            rsp_err     <= 1'b1;
                            rsp_valid   <= 1'b1;
                            alu_op_code <= 2'b00;
                            state_q     <= S_RESP;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_host_sequencer.sv
// tb/tb_alu_host_sequencer.sv - directed-vector bench for alu_host_sequencer
module tb_alu_host_sequencer;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_x = 16'h0000;
    logic [7:0]  req_y = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        alu_begin;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus = 8'h00;
    logic        alu_end = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_host_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
        .alu_outbus(alu_outbus), .alu_end(alu_end)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake a request and check BEGIN, op_code and the operand word sequence.
    task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [7:0] y,
                         input int n, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2);
        logic [7:0] w [3];
        w[0] = w0; w[1] = w1; w[2] = w2;
        req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
        check("req_ready_idle", {15'd0, req_ready}, 16'h0001);
        step();
        req_valid = 1'b0;
        check("begin_first", {15'd0, alu_begin}, 16'h0001);
        check("op_code", {14'd0, alu_op_code}, {14'd0, op});
        check("req_ready_busy", {15'd0, req_ready}, 16'h0000);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                step();
                check("begin_low", {15'd0, alu_begin}, 16'h0000);
            end
            check($sformatf("inbus_w%0d", i), {8'd0, alu_inbus}, {8'd0, w[i]});
        end
        step();
        check("inbus_idle", {8'd0, alu_inbus}, 16'h0000);
    endtask

    // ALU side: push n bytes on outbus, then raise END for one cycle.
    task automatic push_end(input int n, input logic [7:0] b0, input logic [7:0] b1);
        if (n >= 1) begin alu_outbus = b0; step(); end
        if (n >= 2) begin alu_outbus = b1; step(); end
        alu_outbus = 8'hA5;
        alu_end = 1'b1;
        step();
        alu_end = 1'b0;
        alu_outbus = 8'h00;
    endtask

    task automatic take_rsp(input string tag, input logic [15:0] exp, input logic err);
        check({tag, "_valid"}, {15'd0, rsp_valid}, 16'h0001);
        check({tag, "_result"}, rsp_result, exp);
        check({tag, "_err"}, {15'd0, rsp_err}, {15'd0, err});
        check({tag, "_opcode_cleared"}, {14'd0, alu_op_code}, 16'h0000);
        rsp_ready = 1'b1;
        check({tag, "_no_accept"}, {15'd0, req_ready}, 16'h0000);
        step();
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, {15'd0, rsp_valid}, 16'h0000);
        check({tag, "_ready_back"}, {15'd0, req_ready}, 16'h0001);
    endtask

    initial begin
        int cnt;
        #12;
        check("rst_req_ready", {15'd0, req_ready}, 16'h0001);
        check("rst_rsp_valid", {15'd0, rsp_valid}, 16'h0000);
        check("rst_result", rsp_result, 16'h0000);
        check("rst_begin", {15'd0, alu_begin}, 16'h0000);
        check("rst_inbus", {8'd0, alu_inbus}, 16'h0000);
        reset_n = 1'b1;
        step();

        issue(2'b00, 16'h0005, 8'h03, 2, 8'h05, 8'h03, 8'h00);
        push_end(1, 8'h08, 8'h00);
        take_rsp("add", 16'h0008, 1'b0);

        issue(2'b01, 16'h0003, 8'h05, 2, 8'h03, 8'h05, 8'h00);
        push_end(1, 8'hFE, 8'h00);
        take_rsp("sub", 16'hFFFE, 1'b0);

        issue(2'b10, 16'h0012, 8'h0A, 2, 8'h12, 8'h0A, 8'h00);
        push_end(2, 8'h00, 8'hB4);
        take_rsp("mul", 16'h00B4, 1'b0);

        issue(2'b11, 16'h0064, 8'h07, 3, 8'h00, 8'h64, 8'h07);
        push_end(2, 8'h02, 8'h0E);
        take_rsp("div", 16'h020E, 1'b0);

        // END already high when WAIT starts must not complete the operation.
        alu_end = 1'b1;
        issue(2'b10, 16'h0034, 8'h12, 2, 8'h34, 8'h12, 8'h00);
        step(); step();
        check("end_high_ignored", {15'd0, rsp_valid}, 16'h0000);
        alu_end = 1'b0;
        push_end(2, 8'h03, 8'hA8);
        take_rsp("mul2", 16'h03A8, 1'b0);

        // Watchdog expiry.
        issue(2'b00, 16'h0001, 8'h01, 2, 8'h01, 8'h01, 8'h00);
        cnt = 1;
        while (!rsp_valid && cnt < 4 * TIMEOUT) begin
            step();
            cnt++;
        end
        check("timeout_latency_ok", {15'd0, (cnt >= TIMEOUT && cnt <= TIMEOUT + 1)}, 16'h0001);
        for (int i = 0; i < 5; i++) step();
        check("timeout_hold_valid", {15'd0, rsp_valid}, 16'h0001);
        take_rsp("timeout", 16'h0000, 1'b1);

        // Asynchronous reset in WAIT, then a normal operation.
        issue(2'b11, 16'h1234, 8'h56, 3, 8'h12, 8'h34, 8'h56);
        alu_outbus = 8'h77;
        step();
        reset_n = 1'b0;
        #1;
        check("arst_req_ready", {15'd0, req_ready}, 16'h0001);
        check("arst_op_code", {14'd0, alu_op_code}, 16'h0000);
        check("arst_rsp_valid", {15'd0, rsp_valid}, 16'h0000);
        check("arst_result", rsp_result, 16'h0000);
        alu_outbus = 8'h00;
        step();
        reset_n = 1'b1;
        step();
        issue(2'b00, 16'h0010, 8'h20, 2, 8'h10, 8'h20, 8'h00);
        push_end(1, 8'h30, 8'h00);
        take_rsp("post_rst", 16'h0030, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
